clk_mux_sequencer: RTL
======================

// Module: clk_mux_sequencer
// PURPOSE
//  Controller for the clk_mux clock-switch block: holds the downstream MMCM in reset at power-up/after every
//  source change, qualifies clk_ext_active before selecting the external clock, and forces fallback to
//  clk_int when the external clock drops. Counts switch and lock-loss events; retries failed locks.
//  Runs on a free-running clock independent of clk_mux outputs; drives clk_mux clk_int_select/aresetn.
// PARAMETERS
//  RST_CYCLES     16      cycles mmcm_resetn held low per reset pulse (>=1)
//  LOCK_TIMEOUT   100000  cycles to wait for locked before a retry
//  EXT_QUAL       1024    consecutive cycles clk_ext_active must be high before switching to ext
//  SETTLE_CYCLES  64      cycles after a select change before MMCM reset is issued
//  MAX_RETRIES    3       lock timeouts tolerated before entering FAIL
//  CNT_W          16      width of event counters
// PORTS
//  clk              in   1      free-running control clock
//  rst              in   1      asynchronous, active-high reset
//  clk_ext_active   in   1      from clk_mux, asynchronous (synchronised internally)
//  locked           in   1      from clk_mux output MMCM, asynchronous (synchronised internally)
//  prefer_ext       in   1      software request: use external clock when qualified
//  retry            in   1      single-cycle pulse: leave FAIL, restart sequence
//  clk_int_select   out  1      to clk_mux; 1 = internal clock
//  mmcm_resetn      out  1      to clk_mux aresetn; active-low
//  ready            out  1      1 only in RUN
//  lock_fail        out  1      1 only in FAIL
//  state_o          out  3      current state encoding (status register)
//  switch_count     out  CNT_W  completed source changes, saturating
//  lock_loss_count  out  CNT_W  locked falling in RUN, saturating
// BEHAVIOUR
//  - Reset: state=RESET, clk_int_select=1, mmcm_resetn=0, ready=0, lock_fail=0, counters=0, retries=0.
//  - Inputs pass 2-FF sync (2-cycle latency); all decisions use synced ext_s/lock_s. All outputs registered.
//  - ext_ok: qual counter increments while ext_s=1, clears to 0 when ext_s=0; ext_ok=1 once count==EXT_QUAL-1
//    and ext_s still 1 (saturates). want_int = !(prefer_ext && ext_ok).
//  - RESET(0): mmcm_resetn=0 for exactly RST_CYCLES cycles, then WAIT_LOCK.
//  - WAIT_LOCK(1): mmcm_resetn=1. lock_s=1 -> RUN, retries cleared. LOCK_TIMEOUT cycles without lock ->
//    retries+1; if retries reaches MAX_RETRIES -> FAIL else -> RESET.
//  - RUN(2): ready=1. Priority order each cycle:
//    1) clk_int_select=0 and ext_s=0 -> clk_int_select=1 next cycle, -> SWITCH (fallback, counted as switch).
//    2) lock_s falls -> lock_loss_count+1, -> RESET.
//    3) want_int != clk_int_select -> clk_int_select<=want_int, -> SWITCH.
//    If 1) and lock loss coincide: take 1) and also increment lock_loss_count.
//  - SWITCH(3): ready=0, select held; SETTLE_CYCLES cycles then switch_count+1 and -> RESET.
//    ext_s drop while in SWITCH with select=0: select forced to 1, settle counter restarts.
//  - FAIL(4): mmcm_resetn=0, clk_int_select=1, lock_fail=1; retry pulse -> RESET, retries=0.
//  - In RESET/WAIT_LOCK, ext_s=0 with select=0 forces select=1 immediately (no state change).
//  - Counters saturate at all-ones, never wrap. prefer_ext changes are sampled only in RUN.
//  - rst asserted mid-sequence: immediate return to reset values regardless of state.
// STRUCTURE
//  - clk_mux_pkg: state enum seq_state_t {RESET, WAIT_LOCK, RUN, SWITCH, FAIL} (3-bit, encodings above).
//  - Sub-module cdc_sync_bit (2-FF, async reset to 0), instantiated twice. One timer counter shared by
//    RESET/WAIT_LOCK/SWITCH, sized $clog2 of largest timing parameter; separate qual counter.
// TESTING (bench params RST_CYCLES=4, LOCK_TIMEOUT=50, EXT_QUAL=8, SETTLE_CYCLES=5, MAX_RETRIES=3)
//  1 Release rst, locked=1 after 10 cycles -> mmcm_resetn low exactly 4 cycles, ready=1, select=1, counts 0.
//  2 In RUN, prefer_ext=1, ext_active=1 held -> select=0 after 2+8 cycles; 5 settle, switch_count=1,
//    RESET 4 cycles, relock -> RUN.
//  3 Running ext, drop ext_active -> select=1 within 3 cycles of drop (2 sync+1), switch_count=2.
//  4 ext_active pulses high 6 cycles then low, repeated -> select never leaves 1, switch_count unchanged.
//  5 locked never asserts -> 3 timeouts of 50 cycles, FAIL, lock_fail=1, mmcm_resetn=0; retry -> RESET.
//  6 In RUN drop locked 1 cycle -> lock_loss_count=1, RESET re-entered; assert rst mid-SWITCH -> all reset values.

Source files
------------

// File: rtl/clk_mux_sequencer_pkg.sv
// clk_mux_sequencer_pkg: shared state encoding and sizing helpers for the clock-switch sequencer.
package clk_mux_sequencer_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        RESET     = 3'd0,
        WAIT_LOCK = 3'd1,
        RUN       = 3'd2,
        SWITCH    = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction

endpackage

// File: rtl/clk_mux_sequencer_if.sv
// clk_mux_sequencer_if: control/status bundle between the sequencer (slave) and clk_mux/software (master).
interface clk_mux_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             clk_ext_active;
    logic             locked;
    logic             prefer_ext;
    logic             retry;
    logic             clk_int_select;
    logic             mmcm_resetn;
    logic             ready;
    logic             lock_fail;
    logic [2:0]       state_o;
    logic [CNT_W-1:0] switch_count;
    logic [CNT_W-1:0] lock_loss_count;

    modport master (
        output clk_ext_active, locked, prefer_ext, retry,
        input  clk_int_select, mmcm_resetn, ready, lock_fail, state_o, switch_count, lock_loss_count
    );

    modport slave (
        input  clk_ext_active, locked, prefer_ext, retry,
        output clk_int_select, mmcm_resetn, ready, lock_fail, state_o, switch_count, lock_loss_count
    );
endinterface

// File: rtl/clk_mux_sequencer_sync.sv
// cdc_sync_bit: two-flop synchroniser for a single asynchronous level, cleared to 0 on reset.
module cdc_sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) {q, meta} <= 2'b00;
        else     {q, meta} <= {meta, d};
    end
endmodule

// File: rtl/clk_mux_sequencer.sv
// clk_mux_sequencer: sequences clk_mux source selection and MMCM reset, with ext qualification,
// forced fallback to the internal clock, lock retry and saturating event counters.
module clk_mux_sequencer
    import clk_mux_sequencer_pkg::*;
#(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int EXT_QUAL      = 1024,
    parameter int SETTLE_CYCLES = 64,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input logic                clk,
    input logic                rst,
    clk_mux_sequencer_if.slave bus
);
    localparam int TW = $clog2(max3(RST_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES) + 1);
    localparam int QW = $clog2(EXT_QUAL + 1);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    seq_state_t       state, state_n;
    logic [TW-1:0]    timer, timer_n;
    logic [QW-1:0]    qual;
    logic [RW-1:0]    retries, retries_n;
    logic [CNT_W-1:0] sw_cnt, sw_cnt_n, ll_cnt, ll_cnt_n;
    logic             sel, sel_n;
    logic             resetn_q, ready_q, fail_q;
    logic             ext_s, lock_s, ext_ok, want_int, ext_lost;

    cdc_sync_bit u_sync_ext  (.clk(clk), .rst(rst), .d(bus.clk_ext_active), .q(ext_s));
    cdc_sync_bit u_sync_lock (.clk(clk), .rst(rst), .d(bus.locked),         .q(lock_s));

    // qual saturates one short of EXT_QUAL so ext_ok lands on the EXT_QUAL-th high cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                            qual <= '0;
        else if (!ext_s)                    qual <= '0;
        else if (qual != QW'(EXT_QUAL - 1)) qual <= qual + QW'(1);
    end

    assign ext_ok   = ext_s && (qual == QW'(EXT_QUAL - 1));
    assign want_int = !(bus.prefer_ext && ext_ok);
    assign ext_lost = !sel && !ext_s;

    always_comb begin
        state_n   = state;
        timer_n   = timer + TW'(1);
        retries_n = retries;
        sel_n     = sel;
        sw_cnt_n  = sw_cnt;
        ll_cnt_n  = ll_cnt;
        case (state)
            RESET: begin
                sel_n = sel | ext_lost;
                if (timer == TW'(RST_CYCLES - 1)) begin
                    state_n = WAIT_LOCK;
                    timer_n = '0;
                end
            end
            WAIT_LOCK: begin
                sel_n = sel | ext_lost;
                if (lock_s) begin
                    state_n   = RUN;
                    retries_n = '0;
                    timer_n   = '0;
                end else if (timer == TW'(LOCK_TIMEOUT - 1)) begin
                    retries_n = retries + RW'(1);
                    state_n   = (retries_n == RW'(MAX_RETRIES)) ? FAIL : RESET;
                    timer_n   = '0;
                end
            end
            RUN: begin
                timer_n = '0;
                // lock_s is known high on RUN entry, so a low here is a falling edge
                if (ext_lost) begin
                    sel_n    = 1'b1;
                    state_n  = SWITCH;
                    ll_cnt_n = (!lock_s && !(&ll_cnt)) ? ll_cnt + CNT_W'(1) : ll_cnt;
                end else if (!lock_s) begin
                    state_n  = RESET;
                    ll_cnt_n = (&ll_cnt) ? ll_cnt : ll_cnt + CNT_W'(1);
                end else if (want_int != sel) begin
                    sel_n   = want_int;
                    state_n = SWITCH;
                end
            end
            SWITCH: begin
                if (ext_lost) begin
                    sel_n   = 1'b1;
                    timer_n = '0;
                end else if (timer == TW'(SETTLE_CYCLES - 1)) begin
                    state_n  = RESET;
                    timer_n  = '0;
                    sw_cnt_n = (&sw_cnt) ? sw_cnt : sw_cnt + CNT_W'(1);
                end
            end
            default: begin
                sel_n   = 1'b1;
                timer_n = '0;
                if (bus.retry) begin
                    state_n   = RESET;
                    retries_n = '0;
                end
            end
        endcase
        if (state_n == FAIL) sel_n = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RESET;
            timer    <= '0;
            retries  <= '0;
            sel      <= 1'b1;
            sw_cnt   <= '0;
            ll_cnt   <= '0;
            resetn_q <= 1'b0;
            ready_q  <= 1'b0;
            fail_q   <= 1'b0;
        end else begin
            state    <= state_n;
            timer    <= timer_n;
            retries  <= retries_n;
            sel      <= sel_n;
            sw_cnt   <= sw_cnt_n;
            ll_cnt   <= ll_cnt_n;
            resetn_q <= !(state_n == RESET || state_n == FAIL);
            ready_q  <= (state_n == RUN);
            fail_q   <= (state_n == FAIL);
        end
    end

    assign bus.clk_int_select  = sel;
    assign bus.mmcm_resetn     = resetn_q;
    assign bus.ready           = ready_q;
    assign bus.lock_fail       = fail_q;
    assign bus.state_o         = state;
    assign bus.switch_count    = sw_cnt;
    assign bus.lock_loss_count = ll_cnt;
endmodule
